// File: rtl/serial_add_pkg.sv
// Shared constants and FSM encoding for the bit-serial adder controller.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width: $clog2(width), but never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/fulladder.sv
// Single-bit full adder: the whole arithmetic datapath of the serial adder.
module fulladder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic c_o,
    output logic res_o
);

    assign res_o = a_i ^ b_i ^ c_i;
    assign c_o   = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder stepped LSB first, one bit per clock,
// sequenced by an IDLE/RUN/DONE FSM.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);

    localparam int             CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fa_sum;
    logic               fa_carry;

    fulladder u_fa (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .c_i   (carry_q),
        .c_o   (fa_carry),
        .res_o (fa_sum)
    );

    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = c_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
                sum_d   = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
                carry_d = fa_carry;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // carry_q is only reloaded on an accepted start, so it holds the carry-out until then.
    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign c_o    = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_add_ctrl;

    typedef struct packed {
        logic [7:0] sum;
        logic       co;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst8 = 1'b1;
    logic       rst1 = 1'b1;
    logic       start8 = 1'b0;
    logic       start1 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic       c8 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       cin1 = 1'b0;

    logic       busy8, done8, co8;
    logic [7:0] sum8;
    logic       busy1, done1, co1;
    logic [0:0] sum1;

    exp_t q8[$];
    exp_t q1[$];
    exp_t e8, e1;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt8 = 0;
    int   done_cnt1 = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk_i   (clk),
        .rst_i   (rst8),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .c_i     (c8),
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .c_o     (co8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst1),
        .start_i (start1),
        .a_i     (a1),
        .b_i     (b1),
        .c_i     (cin1),
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .c_o     (co1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        exp_t       e;
        r     = {1'b0, a} + {1'b0, b} + {8'b0, c};
        e.sum = r[7:0];
        e.co  = r[8];
        return e;
    endfunction

    function automatic exp_t ref1(input logic a, input logic b, input logic c);
        logic [1:0] r;
        exp_t       e;
        r     = {1'b0, a} + {1'b0, b} + {1'b0, c};
        e.sum = {7'b0, r[0]};
        e.co  = r[1];
        return e;
    endfunction

    // Scoreboard: each done pulse retires the oldest expected result.
    always @(negedge clk) begin
        if (done8) begin
            done_cnt8++;
            if (q8.size() == 0) begin
                check("done8_unexpected", 32'd1, 32'd0);
            end else begin
                e8 = q8.pop_front();
                check("sum8", 32'(sum8), 32'(e8.sum));
                check("co8", 32'(co8), 32'(e8.co));
            end
        end
        if (done1) begin
            done_cnt1++;
            if (q1.size() == 0) begin
                check("done1_unexpected", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                check("sum1", 32'(sum1), 32'(e1.sum));
                check("co1", 32'(co1), 32'(e1.co));
            end
        end
    end

    // Called just after a negedge with dut8 idle; returns at the DONE-cycle negedge.
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic c);
        a8     = a;
        b8     = b;
        c8     = c;
        start8 = 1'b1;
        q8.push_back(ref8(a, b, c));
        @(negedge clk);
        start8 = 1'b0;
        a8     = 8'($urandom);
        b8     = 8'($urandom);
        c8     = 1'($urandom);
        for (int i = 0; i < 8; i++) begin
            check("busy8_run", 32'(busy8), 32'd1);
            check("done8_run", 32'(done8), 32'd0);
            @(negedge clk);
        end
        check("done8_pulse", 32'(done8), 32'd1);
        check("busy8_done", 32'(busy8), 32'd0);
    endtask

    task automatic run_op1(input logic a, input logic b, input logic c);
        a1     = a;
        b1     = b;
        cin1   = c;
        start1 = 1'b1;
        q1.push_back(ref1(a, b, c));
        @(negedge clk);
        start1 = 1'b0;
        a1     = 1'($urandom);
        b1     = 1'($urandom);
        cin1   = 1'($urandom);
        check("busy1_run", 32'(busy1), 32'd1);
        check("done1_run", 32'(done1), 32'd0);
        @(negedge clk);
        check("done1_pulse", 32'(done1), 32'd1);
        check("busy1_done", 32'(busy1), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt0;

        // Reset state, before any clock edge.
        #1;
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_done8", 32'(done8), 32'd0);
        check("rst_sum8", 32'(sum8), 32'd0);
        check("rst_co8", 32'(co8), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        check("rst_sum1", 32'(sum1), 32'd0);

        // First start accepted on the first edge after reset release.
        @(negedge clk);
        rst8 = 1'b0;
        rst1 = 1'b0;
        run_op8(8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        check("idle_done8", 32'(done8), 32'd0);
        check("idle_busy8", 32'(busy8), 32'd0);
        check("hold_sum8", 32'(sum8), 32'h10);
        check("hold_co8", 32'(co8), 32'd0);
        @(negedge clk);
        check("hold2_sum8", 32'(sum8), 32'h10);

        // Carry-out boundaries.
        @(negedge clk);
        run_op8(8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        run_op8(8'hFF, 8'h00, 1'b1);
        @(negedge clk);
        check("hold_co8_carry", 32'(co8), 32'd1);

        // start_i during RUN is ignored.
        cnt0   = done_cnt8;
        a8     = 8'h12;
        b8     = 8'h34;
        c8     = 1'b0;
        start8 = 1'b1;
        q8.push_back(ref8(8'h12, 8'h34, 1'b0));
        @(negedge clk);
        start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1;
        a8     = 8'hAA;
        b8     = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        check("ignore_start_pulses", 32'(done_cnt8 - cnt0), 32'd1);
        check("ignore_start_sum", 32'(sum8), 32'h46);

        // Reset mid-RUN aborts without a done pulse.
        a8     = 8'h5A;
        b8     = 8'h3C;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        cnt0 = done_cnt8;
        rst8 = 1'b1;
        #1;
        check("abort_busy8", 32'(busy8), 32'd0);
        check("abort_done8", 32'(done8), 32'd0);
        check("abort_sum8", 32'(sum8), 32'd0);
        check("abort_co8", 32'(co8), 32'd0);
        @(negedge clk);
        check("abort_hold_busy8", 32'(busy8), 32'd0);
        check("abort_hold_sum8", 32'(sum8), 32'd0);
        rst8 = 1'b0;
        run_op8(8'h80, 8'h80, 1'b0);
        @(negedge clk);
        check("abort_pulses", 32'(done_cnt8 - cnt0), 32'd1);

        // start_i held high: one result every WIDTH+2 cycles.
        cnt0   = done_cnt8;
        a8     = 8'h01;
        b8     = 8'h01;
        c8     = 1'b0;
        start8 = 1'b1;
        for (int r = 0; r < 3; r++) begin
            q8.push_back(ref8(8'h01, 8'h01, 1'b0));
            repeat (9) @(negedge clk);
            check("b2b_done", 32'(done8), 32'd1);
            if (r == 2) start8 = 1'b0;
            @(negedge clk);
        end
        check("b2b_pulses", 32'(done_cnt8 - cnt0), 32'd3);

        // Random operands, both widths.
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            run_op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            run_op1(1'($urandom), 1'($urandom), 1'($urandom));
        end

        @(negedge clk);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
